// File: rtl/csync_sep.sv
// Composite-sync separator: splits an active-low composite sync into a regenerated
// active-low hsync, an active-high vsync, a line counter and a line-period lock flag.
module csync_sep #(
  parameter int LINE_LEN   = 766,
  parameter int LINE_TOL   = 8,
  parameter int HS_WIDTH   = 60,
  parameter int GLITCH_MIN = 8,
  parameter int VS_THRESH  = 384,
  parameter int LOCK_LINES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       csync,
  output logic       hsync,
  output logic       vsync,
  output logic [8:0] line_cnt,
  output logic       locked
);

  localparam int HW = (HS_WIDTH > 1) ? $clog2(HS_WIDTH) : 1;
  localparam int GW = $clog2(LOCK_LINES + 1);

  localparam logic [9:0]    FE_AT   = 10'(GLITCH_MIN - 1);
  localparam logic [9:0]    VS_AT   = 10'(VS_THRESH - 1);
  localparam logic [9:0]    GMIN    = 10'(GLITCH_MIN);
  localparam logic [9:0]    VMIN    = 10'(VS_THRESH);
  localparam logic [10:0]   PER_LO  = 11'(LINE_LEN - LINE_TOL);
  localparam logic [10:0]   PER_HI  = 11'(LINE_LEN + LINE_TOL);
  localparam logic [10:0]   PER_TO  = 11'(2 * LINE_LEN);
  localparam logic [HW-1:0] HS_LAST = HW'(HS_WIDTH - 1);
  localparam logic [GW-1:0] LOCK_N  = GW'(LOCK_LINES);
  localparam logic [GW-1:0] LOCK_M1 = GW'(LOCK_LINES - 1);

  logic          cs_m, cs_s;
  logic [9:0]    low_cnt;
  logic [10:0]   per_cnt;
  logic [HW-1:0] hs_rem;
  logic [GW-1:0] good_cnt;
  logic          started;
  logic          fe, vs_set, vs_clr, good_per, timeout;

  // Edge is confirmed only once the low level has survived GLITCH_MIN clocks.
  assign fe       = !cs_s && (low_cnt == FE_AT);
  assign vs_set   = !cs_s && (low_cnt == VS_AT);
  assign vs_clr   = cs_s && (low_cnt >= GMIN) && (low_cnt < VMIN);
  assign good_per = (per_cnt >= PER_LO) && (per_cnt <= PER_HI);
  assign timeout  = (per_cnt >= PER_TO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_m <= 1'b1;
      cs_s <= 1'b1;
    end else begin
      cs_m <= csync;
      cs_s <= cs_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      low_cnt <= '0;
    else if (cs_s)
      low_cnt <= '0;
    else if (low_cnt != 10'h3FF)
      low_cnt <= low_cnt + 10'd1;
  end

  // A new edge during an active pulse reloads the width, stretching the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync  <= 1'b1;
      hs_rem <= '0;
    end else if (fe) begin
      hsync  <= 1'b0;
      hs_rem <= HS_LAST;
    end else if (!hsync) begin
      if (hs_rem == '0)
        hsync <= 1'b1;
      else
        hs_rem <= hs_rem - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      vsync <= 1'b0;
    else if (vs_set)
      vsync <= 1'b1;
    else if (vs_clr)
      vsync <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      line_cnt <= '0;
    else if (vs_set && !vsync)
      line_cnt <= '0;
    else if (fe && (line_cnt != 9'd511))
      line_cnt <= line_cnt + 9'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      per_cnt <= '0;
    else if (fe)
      per_cnt <= 11'd1;
    else if (per_cnt != 11'h7FF)
      per_cnt <= per_cnt + 11'd1;
  end

  // The first confirmed edge only opens the measurement window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started  <= 1'b0;
      good_cnt <= '0;
      locked   <= 1'b0;
    end else if (fe) begin
      started <= 1'b1;
      if (started) begin
        if (good_per) begin
          if (good_cnt != LOCK_N)
            good_cnt <= good_cnt + 1'b1;
          if (good_cnt >= LOCK_M1)
            locked <= 1'b1;
        end else begin
          good_cnt <= '0;
          locked   <= 1'b0;
        end
      end
    end else if (timeout) begin
      good_cnt <= '0;
      locked   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_csync_sep.sv
// Bench for csync_sep: line/pulse-level stimulus tables, an event-based reference
// model derived from pulse widths and edge times, and per-scenario checks.
module tb_csync_sep;

  localparam int G    = 8;
  localparam int VS   = 384;
  localparam int HW   = 60;
  localparam int LL   = 766;
  localparam int LT   = 8;
  localparam int LN   = 4;
  localparam int TO   = 2 * LL;
  localparam int MAXN = 16384;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       csync;
  logic       hsync, vsync, locked;
  logic [8:0] line_cnt;

  always #5 clk = ~clk;

  csync_sep dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .csync    (csync),
    .hsync    (hsync),
    .vsync    (vsync),
    .line_cnt (line_cnt),
    .locked   (locked)
  );

  int total = 0;
  int bad   = 0;

  int   seg_lo[$];
  int   seg_hi[$];
  bit   stim[MAXN];
  int   n;
  bit   fe_ev[MAXN], vs_ev[MAXN], vc_ev[MAXN];
  logic e_h[MAXN], e_v[MAXN], e_l[MAXN];
  logic [8:0] e_c[MAXN];
  logic o_h[MAXN], o_v[MAXN], o_l[MAXN];
  logic [8:0] o_c[MAXN];

  task automatic add_line(input int lo, input int hi);
    seg_lo.push_back(lo);
    seg_hi.push_back(hi);
  endtask

  task automatic build_stim();
    n = 0;
    while (seg_lo.size() > 0) begin
      int lo;
      int hi;
      lo = seg_lo.pop_front();
      hi = seg_hi.pop_front();
      for (int j = 0; j < lo && n < MAXN; j++) begin stim[n] = 1'b0; n++; end
      for (int j = 0; j < hi && n < MAXN; j++) begin stim[n] = 1'b1; n++; end
    end
  endtask

  // Model: stim[c] is sampled at edge c; a low run starting at index f with width w
  // confirms an edge at f+G+1, raises vsync at f+VS+1 (w >= VS), and a normal
  // pulse (G <= w < VS) clears vsync at f+w+2.
  task automatic build_model();
    int i, f, w, last, good, lc;
    bit v, lk;
    for (int k = 0; k < n; k++) begin fe_ev[k] = 0; vs_ev[k] = 0; vc_ev[k] = 0; end
    i = 0;
    while (i < n) begin
      if (!stim[i]) begin
        f = i;
        while (i < n && !stim[i]) i++;
        w = i - f;
        if (w >= G && f + G + 1 < n) fe_ev[f + G + 1] = 1;
        if (w >= VS && f + VS + 1 < n) vs_ev[f + VS + 1] = 1;
        if (w >= G && w < VS && i < n && f + w + 2 < n) vc_ev[f + w + 2] = 1;
      end else begin
        i++;
      end
    end
    last = -1; good = 0; lc = 0; v = 0; lk = 0;
    for (int k = 0; k < n; k++) begin
      if (fe_ev[k]) begin
        if (last >= 0) begin
          if ((k - last) >= LL - LT && (k - last) <= LL + LT) begin
            if (good < LN) good++;
            if (good >= LN) lk = 1;
          end else begin
            good = 0; lk = 0;
          end
        end
        last = k;
        if (lc < 511) lc++;
      end else if (last >= 0 && (k - last) >= TO) begin
        good = 0; lk = 0;
      end
      if (vs_ev[k]) begin
        if (!v) lc = 0;
        v = 1;
      end else if (vc_ev[k]) begin
        v = 0;
      end
      e_h[k] = !(last >= 0 && (k - last) < HW);
      e_v[k] = v;
      e_l[k] = lk;
      e_c[k] = 9'(lc);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    csync = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_trace();
    do_reset();
    for (int c = 0; c < n; c++) begin
      csync = stim[c];
      @(posedge clk);
      @(negedge clk);
      o_h[c] = hsync; o_v[c] = vsync; o_l[c] = locked; o_c[c] = line_cnt;
    end
    csync = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    csync = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    total++;
    if ({hsync, vsync, locked} !== 3'b100 || line_cnt !== 9'd0) begin
      bad++;
      $display("FAIL reset_values: got h%b v%b l%b n%0d, want h1 v0 l0 n0", hsync, vsync, locked, line_cnt);
    end
    rst_n = 1'b1;
    repeat (2000) @(negedge clk);
    total++;
    if ({hsync, vsync, locked} !== 3'b100 || line_cnt !== 9'd0) begin
      bad++;
      $display("FAIL idle_high: got h%b v%b l%b n%0d, want h1 v0 l0 n0", hsync, vsync, locked, line_cnt);
    end
  endtask

  task automatic test_normal_lines();
    for (int l = 0; l < 10; l++) add_line(60, 706);
    build_stim(); build_model(); run_trace();
    for (int k = 0; k < n; k++) begin
      total++;
      if (o_h[k] !== e_h[k] || o_v[k] !== e_v[k] || o_l[k] !== e_l[k] || o_c[k] !== e_c[k]) begin
        bad++;
        $display("FAIL normal_trace cyc=%0d: got h%b v%b l%b n%0d, want h%b v%b l%b n%0d",
                 k, o_h[k], o_v[k], o_l[k], o_c[k], e_h[k], e_v[k], e_l[k], e_c[k]);
        break;
      end
    end
    total++;
    if ({o_h[8], o_h[9], o_h[68], o_h[69]} !== 4'b1001) begin
      bad++;
      $display("FAIL hsync_latency_width: got %b%b%b%b, want 1001", o_h[8], o_h[9], o_h[68], o_h[69]);
    end
    total++;
    if ({o_l[4*LL+8], o_l[4*LL+9]} !== 2'b01 || o_c[n-1] !== 9'd10) begin
      bad++;
      $display("FAIL lock_on_5th_edge: got l%b%b n%0d, want l01 n10", o_l[4*LL+8], o_l[4*LL+9], o_c[n-1]);
    end
  endtask

  task automatic test_frame();
    int fb, fn;
    for (int l = 0; l < 5; l++) add_line(60, 706);
    add_line(706, 60);
    add_line(706, 60);
    for (int l = 0; l < 5; l++) add_line(60, 706);
    build_stim(); build_model(); run_trace();
    for (int k = 0; k < n; k++) begin
      total++;
      if (o_h[k] !== e_h[k] || o_v[k] !== e_v[k] || o_l[k] !== e_l[k] || o_c[k] !== e_c[k]) begin
        bad++;
        $display("FAIL frame_trace cyc=%0d: got h%b v%b l%b n%0d, want h%b v%b l%b n%0d",
                 k, o_h[k], o_v[k], o_l[k], o_c[k], e_h[k], e_v[k], e_l[k], e_c[k]);
        break;
      end
    end
    fb = 5 * LL;
    fn = fb + 2 * LL;
    total++;
    if ({o_v[fb+384], o_v[fb+385]} !== 2'b01 || o_c[fb+385] !== 9'd0) begin
      bad++;
      $display("FAIL vsync_rise: got v%b%b n%0d, want v01 n0", o_v[fb+384], o_v[fb+385], o_c[fb+385]);
    end
    total++;
    if ({o_v[fn+61], o_v[fn+62]} !== 2'b10 || o_l[n-1] !== 1'b1) begin
      bad++;
      $display("FAIL vsync_fall: got v%b%b l%b, want v10 l1", o_v[fn+61], o_v[fn+62], o_l[n-1]);
    end
  endtask

  task automatic test_glitch();
    int s10;
    for (int l = 0; l < 6; l++) add_line(60, 706);
    add_line(60, 300); add_line(5, 401);
    add_line(60, 300); add_line(3, 403);
    add_line(60, 706); add_line(60, 706);
    add_line(60, 300); add_line(20, 386);
    add_line(60, 706); add_line(60, 706);
    build_stim(); build_model(); run_trace();
    for (int k = 0; k < n; k++) begin
      total++;
      if (o_h[k] !== e_h[k] || o_v[k] !== e_v[k] || o_l[k] !== e_l[k] || o_c[k] !== e_c[k]) begin
        bad++;
        $display("FAIL glitch_trace cyc=%0d: got h%b v%b l%b n%0d, want h%b v%b l%b n%0d",
                 k, o_h[k], o_v[k], o_l[k], o_c[k], e_h[k], e_v[k], e_l[k], e_c[k]);
        break;
      end
    end
    s10 = 10 * LL;
    total++;
    if (o_l[s10+368] !== 1'b1 || o_c[s10+368] !== 9'd11 || o_h[s10+368] !== 1'b1) begin
      bad++;
      $display("FAIL short_glitch_ignored: got l%b n%0d h%b, want l1 n11 h1", o_l[s10+368], o_c[s10+368], o_h[s10+368]);
    end
    total++;
    if (o_l[s10+369] !== 1'b0 || o_c[s10+369] !== 9'd12 || o_h[s10+369] !== 1'b0) begin
      bad++;
      $display("FAIL long_glitch_edge: got l%b n%0d h%b, want l0 n12 h0", o_l[s10+369], o_c[s10+369], o_h[s10+369]);
    end
  endtask

  task automatic test_period_error();
    int s7, s11;
    for (int l = 0; l < 6; l++) add_line(60, 706);
    add_line(60, 720);
    for (int l = 0; l < 6; l++) add_line(60, 706);
    build_stim(); build_model(); run_trace();
    for (int k = 0; k < n; k++) begin
      total++;
      if (o_h[k] !== e_h[k] || o_v[k] !== e_v[k] || o_l[k] !== e_l[k] || o_c[k] !== e_c[k]) begin
        bad++;
        $display("FAIL period_trace cyc=%0d: got h%b v%b l%b n%0d, want h%b v%b l%b n%0d",
                 k, o_h[k], o_v[k], o_l[k], o_c[k], e_h[k], e_v[k], e_l[k], e_c[k]);
        break;
      end
    end
    s7  = 6 * LL + 780;
    s11 = s7 + 4 * LL;
    total++;
    if ({o_l[s7+8], o_l[s7+9]} !== 2'b10) begin
      bad++;
      $display("FAIL long_line_unlock: got %b%b, want 10", o_l[s7+8], o_l[s7+9]);
    end
    total++;
    if ({o_l[s11+8], o_l[s11+9]} !== 2'b01) begin
      bad++;
      $display("FAIL relock_after_4: got %b%b, want 01", o_l[s11+8], o_l[s11+9]);
    end
  endtask

  task automatic test_stuck_low();
    int e;
    for (int l = 0; l < 6; l++) add_line(60, 706);
    add_line(3000, 0);
    build_stim(); build_model(); run_trace();
    for (int k = 0; k < n; k++) begin
      total++;
      if (o_h[k] !== e_h[k] || o_v[k] !== e_v[k] || o_l[k] !== e_l[k] || o_c[k] !== e_c[k]) begin
        bad++;
        $display("FAIL stuck_trace cyc=%0d: got h%b v%b l%b n%0d, want h%b v%b l%b n%0d",
                 k, o_h[k], o_v[k], o_l[k], o_c[k], e_h[k], e_v[k], e_l[k], e_c[k]);
        break;
      end
    end
    e = 6 * LL + 9;
    total++;
    if ({o_l[e+1531], o_l[e+1532]} !== 2'b10) begin
      bad++;
      $display("FAIL stuck_timeout: got %b%b, want 10", o_l[e+1531], o_l[e+1532]);
    end
    total++;
    if (o_v[n-1] !== 1'b1 || o_h[n-1] !== 1'b1 || o_c[n-1] !== 9'd0) begin
      bad++;
      $display("FAIL stuck_end_state: got v%b h%b n%0d, want v1 h1 n0", o_v[n-1], o_h[n-1], o_c[n-1]);
    end
  endtask

  task automatic test_random();
    add_line(30, 20);
    add_line(60, 656);
    for (int l = 0; l < 13; l++) begin
      int r, len, g;
      r = int'($urandom_range(9, 0));
      if (r <= 5) begin
        len = 756 + int'($urandom_range(20, 0));
        add_line(60, len - 60);
      end else if (r == 6) begin
        add_line(706, 60);
      end else if (r == 7) begin
        g = int'($urandom_range(7, 1));
        add_line(60, 300); add_line(g, 406 - g);
      end else if (r == 8) begin
        g = int'($urandom_range(100, 8));
        add_line(60, 300); add_line(g, 406 - g);
      end else begin
        add_line(30, 20); add_line(60, 656);
      end
    end
    build_stim(); build_model(); run_trace();
    for (int k = 0; k < n; k++) begin
      total++;
      if (o_h[k] !== e_h[k] || o_v[k] !== e_v[k] || o_l[k] !== e_l[k] || o_c[k] !== e_c[k]) begin
        bad++;
        $display("FAIL random_trace cyc=%0d: got h%b v%b l%b n%0d, want h%b v%b l%b n%0d",
                 k, o_h[k], o_v[k], o_l[k], o_c[k], e_h[k], e_v[k], e_l[k], e_c[k]);
        break;
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    int lat;
    do_reset();
    csync = 1'b0; repeat (706) @(negedge clk);
    csync = 1'b1; repeat (60) @(negedge clk);
    csync = 1'b0; repeat (20) @(negedge clk);
    total++;
    if (hsync !== 1'b0 || vsync !== 1'b1 || line_cnt !== 9'd1) begin
      bad++;
      $display("FAIL pre_reset_state: got h%b v%b n%0d, want h0 v1 n1", hsync, vsync, line_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({hsync, vsync, locked} !== 3'b100 || line_cnt !== 9'd0) begin
      bad++;
      $display("FAIL async_reset: got h%b v%b l%b n%0d, want h1 v0 l0 n0", hsync, vsync, locked, line_cnt);
    end
    csync = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    csync = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (!hsync) begin lat = i; break; end
    end
    total++;
    if (lat != 2 + G) begin
      bad++;
      $display("FAIL resume_latency: got %0d, want %0d (0 means no hsync within 40 clocks)", lat, 2 + G);
    end
    csync = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    csync = 1'b1;
    test_reset();
    test_normal_lines();
    test_frame();
    test_glitch();
    test_period_error();
    test_stuck_low();
    test_random();
    test_reset_mid_pulse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
